// File: rtl/token_buf_arbiter_if.sv
// Request/grant and buffer-side signal bundle for the token buffer arbiter.
// master = requester/top side, slave = the arbiter.
interface token_buf_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 64
);
    logic [3:0]      rq_valid;
    logic [3:0]      rq_ready;
    logic [3:0]      rq_we;
    logic [4*AW-1:0] rq_addr;
    logic [4*DW-1:0] rq_wdata;
    logic            lock_en;
    logic [1:0]      lock_src;
    logic [1:0]      tb_src_sel;
    logic [3:0]      tb_req;
    logic            tb_we;
    logic [AW-1:0]   tb_addr;
    logic [DW-1:0]   tb_wdata;
    logic            rd_inflight;
    logic            busy;

    modport master (
        output rq_valid, rq_we, rq_addr, rq_wdata, lock_en, lock_src,
        input  rq_ready, tb_src_sel, tb_req, tb_we, tb_addr, tb_wdata, rd_inflight, busy
    );
    modport slave (
        input  rq_valid, rq_we, rq_addr, rq_wdata, lock_en, lock_src,
        output rq_ready, tb_src_sel, tb_req, tb_we, tb_addr, tb_wdata, rd_inflight, busy
    );
endinterface

// File: rtl/token_buf_arbiter.sv
// Round-robin arbiter sharing the single-port token buffer between four requesters,
// with bounded bursts, optional source lock, switch gap and read-in-flight tracking.
module token_buf_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 64,
    parameter int MAX_BURST  = 4,
    parameter int SWITCH_GAP = 1,
    parameter int RD_LAT     = 3
) (
    input logic             clk,
    input logic             rst,
    token_buf_arbiter_if.slave bus
);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, GRANT, REARB, GAP} state_t;

    state_t          state, state_nxt;
    logic [1:0]      cur, rr_ptr, win, src_sel;
    logic [BW-1:0]   burst_cnt;
    logic [2:0]      gap_cnt;
    logic [3:0]      elig, req;
    logic            we, fwe;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [RD_LAT-1:0] rd_sr;
    logic            xfer, rearb, grant_ld, gap_ld, rd_issue;

    // Scan from lowest priority (rr_ptr itself) to highest so the last hit wins.
    function automatic logic [1:0] pick(input logic [3:0] e, input logic [1:0] ptr);
        logic [1:0] idx;
        pick = ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (e[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        elig     = bus.rq_valid & (bus.lock_en ? (4'b0001 << bus.lock_src) : 4'hF);
        win      = pick(elig, rr_ptr);
        xfer     = (state == GRANT) && bus.rq_valid[cur];
        rearb    = (state == GRANT) &&
                   (!bus.rq_valid[cur] || (bus.lock_en && bus.lock_src != cur) ||
                    (xfer && burst_cnt == BW'(MAX_BURST - 1)));
        rd_issue = (|req) && !we;
        case (cur)
            2'd1:    fwe = 1'b0;
            2'd2:    fwe = 1'b1;
            default: fwe = bus.rq_we[cur];
        endcase
    end

    always_comb begin
        state_nxt = state;
        grant_ld  = 1'b0;
        gap_ld    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|elig) begin
                    state_nxt = GRANT;
                    grant_ld  = 1'b1;
                end
            end
            GRANT: begin
                if (rearb) state_nxt = REARB;
            end
            REARB: begin
                if (elig == 4'b0000) begin
                    state_nxt = IDLE;
                end else if (win == cur || SWITCH_GAP == 0) begin
                    state_nxt = GRANT;
                    grant_ld  = 1'b1;
                end else begin
                    state_nxt = GAP;
                    gap_ld    = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt <= 3'd1) begin
                    if (|elig) begin
                        state_nxt = GRANT;
                        grant_ld  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= 2'd0;
            rr_ptr    <= 2'd3;
            src_sel   <= 2'd0;
            burst_cnt <= '0;
            gap_cnt   <= 3'd0;
            req       <= 4'b0000;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rd_sr     <= '0;
        end else begin
            state <= state_nxt;
            if (grant_ld) begin
                cur       <= win;
                src_sel   <= win;
                burst_cnt <= '0;
            end else if (xfer) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (gap_ld)
                gap_cnt <= 3'(SWITCH_GAP);
            else if (state == GAP && gap_cnt != 3'd0)
                gap_cnt <= gap_cnt - 3'd1;
            // Buffer request is registered: one cycle after the handshake.
            req <= xfer ? (4'b0001 << cur) : 4'b0000;
            if (xfer) begin
                rr_ptr <= cur;
                we     <= fwe;
                addr   <= bus.rq_addr[cur*AW +: AW];
                wdata  <= bus.rq_wdata[cur*DW +: DW];
            end
            rd_sr <= (rd_sr << 1) | RD_LAT'(rd_issue);
        end
    end

    assign bus.rq_ready    = (state == GRANT) ? (4'b0001 << cur) : 4'b0000;
    assign bus.tb_src_sel  = src_sel;
    assign bus.tb_req      = req;
    assign bus.tb_we       = we;
    assign bus.tb_addr     = addr;
    assign bus.tb_wdata    = wdata;
    assign bus.rd_inflight = |rd_sr;
    assign bus.busy        = (state != IDLE) || (|rd_sr);

endmodule

// File: tb/tb_token_buf_arbiter.sv
// Bench for token_buf_arbiter: per-cycle transaction/rule model plus directed
// scenarios with hand-computed grant timing.
module tb_token_buf_arbiter;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int RD_LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    token_buf_arbiter_if #(.AW(AW), .DW(DW)) bus();

    token_buf_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4), .SWITCH_GAP(1), .RD_LAT(RD_LAT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_run = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int first_bit(input logic [3:0] v);
        first_bit = 0;
        for (int i = 3; i >= 0; i--) if (v[i]) first_bit = i;
    endfunction

    // traces for directed checks
    logic [3:0]    tr_ready [4096];
    logic [3:0]    tr_req   [4096];
    logic [1:0]    tr_sel   [4096];
    logic [AW-1:0] tr_addr  [4096];
    logic [DW-1:0] tr_wdata [4096];
    logic          tr_we    [4096];
    logic          tr_rdf   [4096];

    // model: next-cycle expectation built from the observed handshake
    logic [3:0]    exp_req = 4'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;
    logic          exp_we = 1'b0;
    int            since_rd = 100;
    bit            armed = 0, after_rst = 0;
    logic [1:0]    prev_sel = 2'd0;

    always @(negedge clk) begin : mon
        logic [3:0] hs;
        int i;
        bit rdf_exp;
        tr_ready[cyc] = bus.rq_ready;
        tr_req[cyc]   = bus.tb_req;
        tr_sel[cyc]   = bus.tb_src_sel;
        tr_addr[cyc]  = bus.tb_addr;
        tr_wdata[cyc] = bus.tb_wdata;
        tr_we[cyc]    = bus.tb_we;
        tr_rdf[cyc]   = bus.rd_inflight;
        if (rst) begin
            exp_req = 4'b0; since_rd = 100; after_rst = 1; armed = 1; prev_sel = 2'd0;
        end else if (armed) begin
            if (after_rst) begin
                chk("rst_ready", bus.rq_ready, 0);
                chk("rst_sel", bus.tb_src_sel, 0);
                chk("rst_req", bus.tb_req, 0);
                chk("rst_we", bus.tb_we, 0);
                chk("rst_addr", bus.tb_addr, 0);
                chk("rst_wdata", bus.tb_wdata, 0);
                chk("rst_rdf", bus.rd_inflight, 0);
                chk("rst_busy", bus.busy, 0);
                after_rst = 0;
            end
            since_rd = (since_rd < 100) ? since_rd + 1 : 100;
            rdf_exp = (since_rd >= 1 && since_rd <= RD_LAT);
            chk("tb_req", bus.tb_req, exp_req);
            if (exp_req != 4'b0) begin
                chk("tb_addr", bus.tb_addr, exp_addr);
                chk("tb_wdata", bus.tb_wdata, exp_wdata);
                chk("tb_we", bus.tb_we, exp_we);
            end
            chk("rd_inflight", bus.rd_inflight, rdf_exp);
            if (exp_req != 4'b0 && !exp_we) since_rd = 0;
            chk("ready_onehot0", $countones(bus.rq_ready) <= 1, 1);
            if (bus.rq_ready != 4'b0)
                chk("sel_vs_ready", bus.tb_src_sel, first_bit(bus.rq_ready));
            if (bus.tb_src_sel != prev_sel)
                chk("sel_change_at_grant", bus.rq_ready != 4'b0, 1);
            prev_sel = bus.tb_src_sel;
            if (bus.rq_ready != 4'b0 || exp_req != 4'b0 || rdf_exp)
                chk("busy", bus.busy, 1);
            hs = bus.rq_valid & bus.rq_ready;
            exp_req = hs;
            if (hs != 4'b0) begin
                i = first_bit(hs);
                exp_addr  = bus.rq_addr[i*AW +: AW];
                exp_wdata = bus.rq_wdata[i*DW +: DW];
                exp_we    = (i == 1) ? 1'b0 : (i == 2) ? 1'b1 : bus.rq_we[i];
            end
        end
    end

    // requester driver
    int            n_left [4];
    logic [AW-1:0] nxt_addr [4];
    logic [DW-1:0] wd [4];
    logic          we_in [4];
    int            hs_src [$];
    int            hs_cyc [$];

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            bus.rq_valid[i] = (n_left[i] > 0);
            bus.rq_we[i]    = we_in[i];
            bus.rq_addr[i*AW +: AW]  = nxt_addr[i];
            bus.rq_wdata[i*DW +: DW] = wd[i];
        end
    endtask

    task automatic run(input int k);
        drive_inputs();
        repeat (k) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (bus.rq_valid[i] && bus.rq_ready[i]) begin
                    n_left[i]--;
                    nxt_addr[i] = nxt_addr[i] + 1'b1;
                    hs_src.push_back(i);
                    hs_cyc.push_back(cyc);
                end
            @(posedge clk); #1;
            drive_inputs();
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < 4; i++) begin
            n_left[i] = 0; we_in[i] = 1'b0; nxt_addr[i] = '0;
            wd[i] = 64'h1111_0000 + 64'(i);
        end
        bus.lock_en = 1'b0; bus.lock_src = 2'd0;
        drive_inputs();
        hs_src.delete(); hs_cyc.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int s;
        rst = 1'b1;
        clear_src();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // DRAM only: 6 writes, burst of 4, 1-cycle re-arb, then 2 more
        clear_src(); do_reset();
        n_left[0] = 6; nxt_addr[0] = 8'h10; we_in[0] = 1'b1;
        s = cyc; run(12);
        for (int j = 0; j < 8; j++)
            chk("t1_ready", tr_ready[s+j], (j >= 1 && j != 5) ? 4'b0001 : 4'b0000);
        for (int j = 0; j < 10; j++)
            chk("t1_req", tr_req[s+j], (j inside {2, 3, 4, 5, 7, 8}) ? 4'b0001 : 4'b0000);
        for (int j = 2; j <= 5; j++) chk("t1_addr", tr_addr[s+j], 8'h10 + 8'(j - 2));
        chk("t1_addr14", tr_addr[s+7], 8'h14);
        chk("t1_addr15", tr_addr[s+8], 8'h15);
        chk("t1_we", tr_we[s+2], 1);
        chk("t1_wdata", tr_wdata[s+2], 64'h1111_0000);
        for (int j = 1; j <= 9; j++) chk("t1_sel", tr_sel[s+j], 0);
        chk("t1_nxfer", hs_src.size(), 6);

        // all four valid: 0,1,2,3,0,... bursts of 4 every 6 cycles
        clear_src(); do_reset();
        for (int i = 0; i < 4; i++) begin
            n_left[i] = 8; nxt_addr[i] = 8'(i * 8'h40); we_in[i] = 1'b1;
        end
        s = cyc; run(52);
        chk("t2_nxfer", hs_src.size(), 32);
        for (int k = 0; k < 32 && k < hs_src.size(); k++) begin
            chk("t2_src", hs_src[k], (k / 4) % 4);
            chk("t2_cyc", hs_cyc[k] - s, 1 + 6 * (k / 4) + k % 4);
        end
        for (int b = 0; b < 4; b++) chk("t2_sel", tr_sel[s+1+6*b], b);
        chk("t2_rearb_rdy", tr_ready[s+5], 0);
        chk("t2_gap_rdy", tr_ready[s+6], 0);
        chk("t2_gap_sel", tr_sel[s+6], 0);
        chk("t2_next_rdy", tr_ready[s+7], 4'b0010);

        // dispatcher we=1 is forced to a read
        clear_src(); do_reset();
        n_left[1] = 1; nxt_addr[1] = 8'h20; we_in[1] = 1'b1;
        s = cyc; run(8);
        chk("t3_req", tr_req[s+2], 4'b0010);
        chk("t3_we", tr_we[s+2], 0);
        chk("t3_addr", tr_addr[s+2], 8'h20);
        for (int j = 2; j <= 6; j++)
            chk("t3_rdf", tr_rdf[s+j], (j >= 3 && j <= 5) ? 1 : 0);

        // collector we=0 is forced to a write
        clear_src(); do_reset();
        n_left[2] = 1; nxt_addr[2] = 8'h30; we_in[2] = 1'b0; wd[2] = 64'hDEAD;
        s = cyc; run(8);
        chk("t4_req", tr_req[s+2], 4'b0100);
        chk("t4_we", tr_we[s+2], 1);
        chk("t4_wdata", tr_wdata[s+2], 64'hDEAD);
        for (int j = 0; j < 8; j++) chk("t4_rdf", tr_rdf[s+j], 0);

        // lock to Gating, drop lock mid second burst
        clear_src(); do_reset();
        for (int i = 0; i < 4; i++) begin n_left[i] = 20; nxt_addr[i] = 8'(i * 8'h40); end
        bus.lock_en = 1'b1; bus.lock_src = 2'd3;
        s = cyc; run(7);
        bus.lock_en = 1'b0;
        run(8);
        chk("t5_nxfer_ge9", hs_src.size() >= 9, 1);
        for (int k = 0; k < 8 && k < hs_src.size(); k++) chk("t5_locked_src", hs_src[k], 3);
        if (hs_src.size() >= 9) begin
            chk("t5_after_src", hs_src[8], 0);
            chk("t5_after_cyc", hs_cyc[8] - s, 12);
        end
        chk("t5_rearb_rdy", tr_ready[s+5], 0);
        chk("t5_regrant_rdy", tr_ready[s+6], 4'b1000);
        chk("t5_gap_rdy", tr_ready[s+11], 0);

        // reset in the middle of a Gating burst
        clear_src(); do_reset();
        for (int i = 0; i < 4; i++) begin n_left[i] = 20; nxt_addr[i] = 8'(i * 8'h40 + 8'h5); end
        bus.lock_en = 1'b1; bus.lock_src = 2'd3;
        s = cyc; run(3);
        do_reset();
        bus.lock_en = 1'b0;
        chk("t6_sel_before", tr_sel[s+2], 3);
        hs_src.delete(); hs_cyc.delete();
        s = cyc; run(4);
        chk("t6_req_after_rst", tr_req[s], 0);
        chk("t6_sel_after_rst", tr_sel[s], 0);
        chk("t6_first_rdy", tr_ready[s+1], 4'b0001);
        chk("t6_first_src", (hs_src.size() > 0) ? hs_src[0] : -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
